abs_val_arbiter: RTL and testbench
==================================

Name: abs_val_arbiter

Overview:
- Shares one 11-bit-signed to 10-bit-magnitude datapath among NUM_REQ requesters, e.g. per-channel ultrasound range-error magnitudes in FPGA Phone Home.
- Round-robin arbitration, registered operand and result, req/ack handshake.
- Sits between the distance/angle calculators and the single magnitude unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of requester index; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request, level; held until ack.
- operands  input  NUM_REQ*11  packed signed operands; requester i uses bits [11*i+10 : 11*i]; stable while req[i] is high.
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the served requester.
- result  output  10  magnitude of the served operand.
- result_id  output  IDX_W  index of the served requester.
- result_valid  output  1  one-cycle pulse, coincident with ack.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async) values:
  - state=IDLE, rr_ptr=0, ack=0, result=0, result_id=0, result_valid=0, busy=0.
  - Internal operand register cleared.
- FSM states:
  - IDLE: if any req bit is high, grant the first set bit searching from rr_ptr upward with wrap. On the clock edge, latch grant_idx and operands[grant_idx], then go to COMPUTE. With no req, stay in IDLE.
  - COMPUTE: the shared magnitude unit sees the latched operand. On the edge, register result, set result_id=grant_idx, result_valid=1, ack[grant_idx]=1, then go to RESULT.
  - RESULT: outputs held for exactly this one cycle. On the edge, clear ack and result_valid, set rr_ptr=(grant_idx+1) mod NUM_REQ, then go to IDLE.
  - result and result_id hold their values after RESULT until the next service.
- Timing:
  - Latency: req sampled at edge N gives result_valid/ack high during the cycle after edge N+1.
  - Throughput: one service per 3 cycles.
- Handshake:
  - Requester deasserts req (or presents a new operand) on the edge where it sees ack high.
  - If req is still high in the following IDLE, it is a new request and is arbitrated normally; round-robin keeps it behind other pending requesters.
- Arithmetic:
  - Operands in -1023..1023 give the exact magnitude.
  - Operand -1024 (11'h400) has no 10-bit magnitude; handling is defined under Optional Feature.
- Boundary conditions:
  - req withdrawn during COMPUTE/RESULT: operation still completes and ack still pulses.
  - operands changing after capture: no effect.
  - Simultaneous requests: exactly one grant, by round-robin.
  - All NUM_REQ requesters asserting continuously: each is served once every 3*NUM_REQ cycles.
  - Reset asserted mid-operation: immediate return to reset values with no ack pulse; the pending service is lost.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: ABS_ARB_SATURATE_EN.
- Defined: operand -1024 yields result=10'd1023, with a registered sat_flag output (1 bit, coincident with result_valid, reset 0) high for that service.
- Undefined: operand -1024 yields the raw datapath output 10'd0 (two's-complement truncation). No sat_flag port exists.

Decomposition:
- Shared package:
  - OPERAND_W=11, RESULT_W=10.
  - State typedef/encoding: IDLE=2'd0, COMPUTE=2'd1, RESULT=2'd2.
  - Saturation constant 10'd1023.
- One sub-module is natural: a single instance of the existing combinational magnitude datapath (abs_val_10), fed from the latched operand register.
- Round-robin priority search stays inline.

Test Plan:
- Single request: req[2]=1, operand2=-5 → ack[2] and result_valid high 2 edges later, result=5, result_id=2, busy high for 2 cycles.
- Simultaneous requests: req=4'b1011 held continuously, operands 3, -7, x, 100 → services in order 0, 1, 3, 0, ... with results 3, 7, 100, 3; each ack is a one-cycle pulse, 3 cycles apart.
- Fairness: all four req high for 24 cycles → exactly 8 services, 2 per requester, rr_ptr back to 0.
- Boundaries:
  - operand 1023 gives 1023; operand 0 gives 0; operand -1023 gives 1023.
  - operand -1024 gives 0 (macro off), or 1023 with sat_flag=1 (macro on).
- Reset mid-operation: assert reset during COMPUTE → all outputs 0 asynchronously, no ack. After release, a pending req[1] is served with result_id=1, since rr_ptr=0 and req[0] is low.
- Withdrawn request: req[3] dropped during COMPUTE → ack[3] still pulses with the correct result, then FSM idles with busy=0.

Source files
------------

// File: rtl/abs_val_arbiter_pkg.sv
// Shared widths, state encoding and saturation constant for the abs_val_arbiter slice.
package abs_val_arbiter_pkg;

    localparam int OPERAND_W = 11;
    localparam int RESULT_W  = 10;

    localparam logic [RESULT_W-1:0]  SAT_VALUE   = 10'd1023;
    localparam logic [OPERAND_W-1:0] OPERAND_MIN = 11'h400;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESULT  = 2'd2
    } state_t;

endpackage

// File: rtl/abs_val_arbiter_abs_val_10.sv
// Combinational 11-bit signed to 10-bit magnitude; -1024 truncates to 0.
module abs_val_arbiter_abs_val_10
    import abs_val_arbiter_pkg::*;
(
    input  logic [OPERAND_W-1:0] operand,
    output logic [RESULT_W-1:0]  magnitude
);

    assign magnitude = RESULT_W'(operand[OPERAND_W-1] ? -operand : operand);

endmodule

// File: rtl/abs_val_arbiter.sv
// Round-robin arbiter sharing one magnitude datapath among NUM_REQ requesters.
// Define ABS_ARB_SATURATE_EN to saturate -1024 to 1023 and add the sat_flag output.
//   state   | meaning
//   IDLE    | waiting for any req; grant and operand capture on the edge
//   COMPUTE | magnitude unit sees the latched operand; result registered on the edge
//   RESULT  | ack/result_valid high for this one cycle; rr_ptr advances on the edge
module abs_val_arbiter
    import abs_val_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*OPERAND_W-1:0]   operands,
    output logic [NUM_REQ-1:0]             ack,
    output logic [RESULT_W-1:0]            result,
    output logic [IDX_W-1:0]               result_id,
    output logic                           result_valid,
`ifdef ABS_ARB_SATURATE_EN
    output logic                           sat_flag,
`endif
    output logic                           busy
);

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [OPERAND_W-1:0]   op_reg;

    logic                   found;
    logic [IDX_W-1:0]       next_grant;
    logic [OPERAND_W-1:0]   next_op;
    logic [RESULT_W-1:0]    magnitude;
    int                     scan;

    // First set req bit at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found      = 1'b0;
        next_grant = '0;
        scan       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[scan]) begin
                found      = 1'b1;
                next_grant = IDX_W'(scan);
            end
        end
    end

    always_comb begin
        next_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (next_grant == IDX_W'(i)) begin
                next_op = operands[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

    abs_val_arbiter_abs_val_10 u_abs_val_10 (
        .operand   (op_reg),
        .magnitude (magnitude)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            op_reg       <= '0;
            ack          <= '0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef ABS_ARB_SATURATE_EN
            sat_flag     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= next_grant;
                        op_reg    <= next_op;
                        busy      <= 1'b1;
                        state     <= COMPUTE;
                    end
                end
                COMPUTE: begin
`ifdef ABS_ARB_SATURATE_EN
                    result   <= (op_reg == OPERAND_MIN) ? SAT_VALUE : magnitude;
                    sat_flag <= (op_reg == OPERAND_MIN);
`else
                    result   <= magnitude;
`endif
                    result_id    <= grant_idx;
                    result_valid <= 1'b1;
                    ack          <= NUM_REQ'(1) << grant_idx;
                    state        <= RESULT;
                end
                RESULT: begin
                    ack          <= '0;
                    result_valid <= 1'b0;
`ifdef ABS_ARB_SATURATE_EN
                    sat_flag     <= 1'b0;
`endif
                    if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant_idx + IDX_W'(1);
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abs_val_arbiter.sv
// Self-checking bench for abs_val_arbiter against a transaction-level round-robin model.
module tb_abs_val_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [43:0] operands;
    logic [3:0]  ack;
    logic [9:0]  result;
    logic [1:0]  result_id;
    logic        result_valid;
    logic        busy;
`ifdef ABS_ARB_SATURATE_EN
    logic        sat_flag;
`endif

    int errors = 0;
    int checks = 0;
    int m_ptr  = 0;
    int ops [4];

    abs_val_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .operands     (operands),
        .ack          (ack),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
`ifdef ABS_ARB_SATURATE_EN
        .sat_flag     (sat_flag),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_mag(input int v);
        if (v == -1024) begin
`ifdef ABS_ARB_SATURATE_EN
            return 1023;
`else
            return 0;
`endif
        end
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic ref_sat(input int v);
`ifdef ABS_ARB_SATURATE_EN
        return v == -1024;
`else
        return (v == -1024) && 1'b0;
`endif
    endfunction

    function automatic int pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic cur_sat();
`ifdef ABS_ARB_SATURATE_EN
        return sat_flag;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_op(input int i, input int v);
        ops[i] = v;
        operands[i*11 +: 11] = 11'(v);
    endtask

    task automatic rand_op(input int i);
        set_op(i, int'($urandom_range(0, 2047)) - 1024);
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // Drives one request mask from IDLE and captures the first service (bounded).
    task automatic serve(input logic [3:0] mask, output logic got, output int lat,
                         output logic [9:0] r, output logic [1:0] rid,
                         output logic [3:0] a, output logic s);
        req = mask; got = 1'b0; lat = 0; r = '0; rid = '0; a = '0; s = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1'b1; lat = c; r = result; rid = result_id; a = ack; s = cur_sat();
            end
        end
        req = '0;
        if (got) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; operands = '0;
        for (int i = 0; i < 4; i++) ops[i] = 0;
        @(negedge clk);
        checks++;
        if ({ack, result, result_id, result_valid, busy, cur_sat()} !== 19'd0) begin
            errors++;
            $display("FAIL reset_values: got ack=%b result=%0d id=%0d valid=%b busy=%b, want all 0",
                     ack, result, result_id, result_valid, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic test_single();
        set_op(2, -5);
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_compute: busy=%b valid=%b, want busy=1 valid=0", busy, result_valid);
        end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || ack !== 4'b0100 || result !== 10'd5 || result_id !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_result: valid=%b ack=%b result=%0d id=%0d busy=%b, want 1 0100 5 2 1",
                     result_valid, ack, result, result_id, busy);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || result !== 10'd5 || result_id !== 2'd2) begin
            errors++;
            $display("FAIL single_after: valid=%b ack=%b busy=%b result=%0d id=%0d, want 0 0000 0 5 2",
                     result_valid, ack, busy, result, result_id);
        end
        m_ptr = 3;
    endtask

    task automatic test_simultaneous();
        int order [4];
        int n;
        do_reset();
        set_op(0, 3); set_op(1, -7); rand_op(2); set_op(3, 100);
        req = 4'b1011;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (c % 3 == 2) begin
                int id;
                id = pick(4'b1011, m_ptr);
                if (result_valid !== 1'b1 || ack !== (4'b0001 << id) || result_id !== 2'(id) ||
                    result !== 10'(ref_mag(ops[id]))) begin
                    errors++;
                    $display("FAIL simul_service%0d: valid=%b ack=%b id=%0d result=%0d, want 1 id=%0d result=%0d",
                             n, result_valid, ack, result_id, result, id, ref_mag(ops[id]));
                end
                if (n < 4) order[n] = int'(result_id);
                n++;
                m_ptr = (id + 1) % 4;
            end else if (result_valid !== 1'b0 || ack !== 4'b0000 || busy !== (c % 3 == 1)) begin
                errors++;
                $display("FAIL simul_gap%0d: valid=%b ack=%b busy=%b, want 0 0000 %0b",
                         c, result_valid, ack, busy, (c % 3 == 1));
            end
        end
        req = '0;
        checks++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 3 || order[3] != 0) begin
            errors++;
            $display("FAIL simul_order: got %0d %0d %0d %0d, want 0 1 3 0",
                     order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_fairness();
        int cnt [4];
        int total;
        logic got; int lat; logic [9:0] r; logic [1:0] rid; logic [3:0] a; logic s;
        do_reset();
        for (int i = 0; i < 4; i++) begin rand_op(i); cnt[i] = 0; end
        total = 0;
        req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (result_valid) begin
                int id;
                id = pick(4'b1111, m_ptr);
                checks++;
                if (result_id !== 2'(id) || result !== 10'(ref_mag(ops[id]))) begin
                    errors++;
                    $display("FAIL fair_service: id=%0d result=%0d, want id=%0d result=%0d",
                             result_id, result, id, ref_mag(ops[id]));
                end
                cnt[result_id]++;
                total++;
                m_ptr = (id + 1) % 4;
            end
        end
        req = '0;
        checks++;
        if (total != 8 || cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2) begin
            errors++;
            $display("FAIL fair_counts: total=%0d per=%0d/%0d/%0d/%0d, want 8 and 2 each",
                     total, cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        @(negedge clk);
        serve(4'b1111, got, lat, r, rid, a, s);
        checks++;
        if (got !== 1'b1 || rid !== 2'd0) begin
            errors++;
            $display("FAIL fair_ptr_wrap: got=%b id=%0d, want service to id 0", got, rid);
        end
        m_ptr = 1;
    endtask

    task automatic test_boundaries();
        int vals [6] = '{1023, 0, -1023, -1024, -1, 1};
        logic got; int lat; logic [9:0] r; logic [1:0] rid; logic [3:0] a; logic s;
        for (int j = 0; j < 6; j++) begin
            int id;
            id = j % 4;
            set_op(id, vals[j]);
            serve(4'b0001 << id, got, lat, r, rid, a, s);
            checks++;
            if (got !== 1'b1 || lat != 2 || r !== 10'(ref_mag(vals[j])) || rid !== 2'(id) ||
                s !== ref_sat(vals[j])) begin
                errors++;
                $display("FAIL boundary_%0d: got=%b lat=%0d result=%0d id=%0d sat=%b, want 1 2 %0d %0d %b",
                         vals[j], got, lat, r, rid, s, ref_mag(vals[j]), id, ref_sat(vals[j]));
            end
            m_ptr = (id + 1) % 4;
        end
    endtask

    task automatic test_reset_mid();
        logic got; int lat; logic [9:0] r; logic [1:0] rid; logic [3:0] a; logic s;
        set_op(2, -9);
        req = 4'b0100;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ack, result, result_id, result_valid, busy} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_async: ack=%b result=%0d id=%0d valid=%b busy=%b, want all 0",
                     ack, result, result_id, result_valid, busy);
        end
        req = 4'b0010;
        set_op(1, -77);
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_noack: ack=%b valid=%b, want 0000 0", ack, result_valid);
        end
        reset = 1'b0;
        m_ptr = 0;
        serve(4'b0010, got, lat, r, rid, a, s);
        checks++;
        if (got !== 1'b1 || rid !== 2'd1 || r !== 10'd77 || a !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_resume: got=%b id=%0d result=%0d ack=%b, want 1 1 77 0010",
                     got, rid, r, a);
        end
        m_ptr = 2;
    endtask

    task automatic test_withdrawn();
        set_op(3, -300);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        set_op(3, 55);
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || ack !== 4'b1000 || result !== 10'd300 || result_id !== 2'd3) begin
            errors++;
            $display("FAIL withdrawn_ack: valid=%b ack=%b result=%0d id=%0d, want 1 1000 300 3",
                     result_valid, ack, result, result_id);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL withdrawn_idle: busy=%b valid=%b ack=%b, want 0 0 0000", busy, result_valid, ack);
        end
        m_ptr = 0;
    endtask

    task automatic test_random();
        logic got; int lat; logic [9:0] r; logic [1:0] rid; logic [3:0] a; logic s;
        for (int t = 0; t < 40; t++) begin
            logic [3:0] mask;
            int id;
            mask = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) rand_op(i);
            if (t % 8 == 3) set_op(int'($urandom_range(0, 3)), -1024);
            id = pick(mask, m_ptr);
            serve(mask, got, lat, r, rid, a, s);
            checks++;
            if (id < 0) begin
                if (got !== 1'b0) begin
                    errors++;
                    $display("FAIL random_idle%0d: service to id %0d with no req", t, rid);
                end
            end else begin
                if (got !== 1'b1 || lat != 2 || rid !== 2'(id) || a !== (4'b0001 << id) ||
                    r !== 10'(ref_mag(ops[id])) || s !== ref_sat(ops[id])) begin
                    errors++;
                    $display("FAIL random%0d: got=%b lat=%0d id=%0d ack=%b result=%0d sat=%b, want 1 2 %0d result=%0d sat=%b",
                             t, got, lat, rid, a, r, s, id, ref_mag(ops[id]), ref_sat(ops[id]));
                end
                m_ptr = (id + 1) % 4;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_boundaries();
        test_reset_mid();
        test_withdrawn();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
